// File: rtl/frame_mem_arbiter.sv
// Single-port frame RAM arbiter: display reads take every slot they need, writers A/B share the
// rest round-robin with bounded bursts. Define FRAME_ARB_WB_EN to enable writer B arbitration.
module frame_mem_arbiter #(
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BURST_MAX = 8
) (
   input  logic              CLK_PX,
   input  logic              RST_n,
   input  logic              DISP_REQ,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   output logic [DATA_W-1:0] DISP_DATA,
   output logic              DISP_VALID,
   input  logic              WA_VALID,
   output logic              WA_READY,
   input  logic [ADDR_W-1:0] WA_ADDR,
   input  logic [DATA_W-1:0] WA_DATA,
   input  logic              WB_VALID,
   output logic              WB_READY,
   input  logic [ADDR_W-1:0] WB_ADDR,
   input  logic [DATA_W-1:0] WB_DATA,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_WE,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              DISP_UNDERRUN
);

   localparam int unsigned CntW = $clog2(BURST_MAX + 1);
   localparam logic [CntW-1:0] BurstMax = CntW'(BURST_MAX);

`ifdef FRAME_ARB_WB_EN
   typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;
`else
   typedef enum logic [1:0] {StIdle, StGntA} state_e;
`endif

   state_e state_q, state_d;
   logic   wa_fire, wb_fire;

   assign WA_READY = (state_q == StGntA) && !DISP_REQ;
   assign wa_fire  = WA_VALID && WA_READY;

`ifdef FRAME_ARB_WB_EN
   logic            last_b_q, last_b_d;
   logic [CntW-1:0] burst_q, burst_d, burst_inc;

   assign WB_READY = (state_q == StGntB) && !DISP_REQ;
   assign wb_fire  = WB_VALID && WB_READY;

   always_comb begin
      state_d   = state_q;
      last_b_d  = last_b_q;
      burst_inc = burst_q;
      // Only transferred beats count, so display stalls never shorten a burst.
      if ((wa_fire || wb_fire) && (burst_q != BurstMax)) burst_inc = burst_q + 1'b1;
      burst_d = burst_inc;
      unique case (state_q)
         StIdle: begin
            if (WA_VALID && (!WB_VALID || last_b_q)) state_d = StGntA;
            else if (WB_VALID)                       state_d = StGntB;
         end
         StGntA: begin
            if (!WA_VALID || ((burst_inc == BurstMax) && WB_VALID))
               state_d = WB_VALID ? StGntB : StIdle;
         end
         StGntB: begin
            if (!WB_VALID || ((burst_inc == BurstMax) && WA_VALID))
               state_d = WA_VALID ? StGntA : StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) burst_d = '0;
      if (state_q == StGntA)      last_b_d = 1'b0;
      else if (state_q == StGntB) last_b_d = 1'b1;
   end

   always_ff @(posedge CLK_PX or negedge RST_n) begin
      if (!RST_n) begin
         last_b_q <= 1'b1;
         burst_q  <= '0;
      end else begin
         last_b_q <= last_b_d;
         burst_q  <= burst_d;
      end
   end
`else
   logic unused_wb;

   assign WB_READY  = 1'b0;
   assign wb_fire   = 1'b0;
   assign unused_wb = WB_VALID ^ (BurstMax != '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (WA_VALID)  state_d = StGntA;
         StGntA:  if (!WA_VALID) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end
`endif

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              rd1_q, rd1_d, rd2_q, rd2_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;
   logic              disp_valid_q, disp_valid_d;
   logic              underrun_q, underrun_d;

   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      rd1_d       = DISP_REQ;
      if (DISP_REQ) begin
         mem_addr_d = DISP_ADDR;
      end else if (wa_fire) begin
         mem_addr_d  = WA_ADDR;
         mem_wdata_d = WA_DATA;
         mem_we_d    = 1'b1;
      end else if (wb_fire) begin
         mem_addr_d  = WB_ADDR;
         mem_wdata_d = WB_DATA;
         mem_we_d    = 1'b1;
      end
      // rd1: address on the RAM port, rd2: RAM data returning, then captured for display.
      rd2_d        = rd1_q;
      disp_valid_d = rd2_q;
      disp_data_d  = rd2_q ? MEM_RDATA : disp_data_q;
      underrun_d   = underrun_q | (mem_we_q & rd1_q);
   end

   always_ff @(posedge CLK_PX or negedge RST_n) begin
      if (!RST_n) begin
         state_q      <= StIdle;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         rd1_q        <= 1'b0;
         rd2_q        <= 1'b0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
         underrun_q   <= underrun_d;
      end
   end

   assign MEM_ADDR      = mem_addr_q;
   assign MEM_WDATA     = mem_wdata_q;
   assign MEM_WE        = mem_we_q;
   assign DISP_DATA     = disp_data_q;
   assign DISP_VALID    = disp_valid_q;
   assign DISP_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Covers display streaming, writer bursts, display stalls, reset mid-burst and writer B config.
module tb_frame_mem_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;

   logic          CLK_PX = 1'b0;
   logic          RST_n  = 1'b1;
   logic          DISP_REQ = 1'b0;
   logic [AW-1:0] DISP_ADDR = '0;
   logic [DW-1:0] DISP_DATA;
   logic          DISP_VALID;
   logic          WA_VALID = 1'b0;
   logic          WA_READY;
   logic [AW-1:0] WA_ADDR = '0;
   logic [DW-1:0] WA_DATA = '0;
   logic          WB_VALID = 1'b0;
   logic          WB_READY;
   logic [AW-1:0] WB_ADDR = '0;
   logic [DW-1:0] WB_DATA = '0;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_WE;
   logic [DW-1:0] MEM_WDATA;
   logic [DW-1:0] MEM_RDATA;
   logic          DISP_UNDERRUN;

   frame_mem_arbiter dut (
      .CLK_PX(CLK_PX), .RST_n(RST_n),
      .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
      .WA_VALID(WA_VALID), .WA_READY(WA_READY), .WA_ADDR(WA_ADDR), .WA_DATA(WA_DATA),
      .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
      .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
      .DISP_UNDERRUN(DISP_UNDERRUN)
   );

   always #20 CLK_PX = ~CLK_PX;

   logic [7:0] ram [0:1023];
   logic       do_preload = 1'b0;
   always @(posedge CLK_PX) begin
      if (do_preload) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 8'(i);
      end else begin
         if (MEM_WE) ram[MEM_ADDR[9:0]] <= MEM_WDATA;
         MEM_RDATA <= ram[MEM_ADDR[9:0]];
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int log_addr[$];
   int log_data[$];
   int log_cyc[$];
   int rdy_bad, wb_rdy_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Streams writer beats for a fixed number of cycles, logging every MEM write seen.
   task automatic run(input int na, input int base_a, input int nb, input int base_b,
                      input bit toggle, input int cycles);
      int ia, ib;
      bit fa, fb, act;
      ia = 0; ib = 0; fa = 0; fb = 0;
      log_addr.delete(); log_data.delete(); log_cyc.delete();
      rdy_bad = 0; wb_rdy_cnt = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK_PX);
         if (MEM_WE) begin
            log_addr.push_back(int'(MEM_ADDR));
            log_data.push_back(int'(MEM_WDATA));
            log_cyc.push_back(c);
         end
         if (fa) ia++;
         if (fb) ib++;
         act = (c < cycles - 3);
         WA_VALID  = act && (ia < na);
         WA_ADDR   = AW'(base_a + ia);
         WA_DATA   = DW'(8'hA0 + ia);
         WB_VALID  = act && (ib < nb);
         WB_ADDR   = AW'(base_b + ib);
         WB_DATA   = DW'(8'h50 + ib);
         DISP_REQ  = toggle && (c % 2 == 1);
         DISP_ADDR = '0;
         #1;
         if (DISP_REQ && (WA_READY || WB_READY)) rdy_bad++;
         if (WB_READY) wb_rdy_cnt++;
         fa = WA_VALID && WA_READY;
         fb = WB_VALID && WB_READY;
      end
      WA_VALID = 1'b0; WB_VALID = 1'b0; DISP_REQ = 1'b0;
   endtask

   // Issues n back-to-back display reads and checks the returned stream.
   task automatic disp_read(input string tag, input int base, input int n, input int dbase);
      int nvalid, bad, first, wes;
      nvalid = 0; bad = 0; first = -1; wes = 0;
      for (int j = 0; j < n + 5; j++) begin
         @(negedge CLK_PX);
         if (MEM_WE) wes++;
         if (DISP_VALID) begin
            nvalid++;
            if (first < 0) first = j;
            if ((j < 3) || (int'(DISP_DATA) != ((dbase + j - 3) & 255))) bad++;
         end else if ((j >= 3) && (j < n + 3)) begin
            bad++;
         end
         DISP_REQ  = (j < n);
         DISP_ADDR = AW'(base + j);
      end
      DISP_REQ = 1'b0;
      check({tag, "_first_valid"}, first, 3);
      check({tag, "_valid_count"}, nvalid, n);
      check({tag, "_data_bad"}, bad, 0);
      check({tag, "_no_we"}, wes, 0);
   endtask

   task automatic do_reset();
      @(negedge CLK_PX);
      RST_n = 1'b0;
      @(negedge CLK_PX);
      RST_n = 1'b1;
   endtask

   initial begin
      int bad, ia, got_addr, got_data;
      bit fa, seen;

      #2 RST_n = 1'b0;
      #1;
      check("rst_mem_addr", MEM_ADDR, 0);
      check("rst_mem_we", MEM_WE, 0);
      check("rst_mem_wdata", MEM_WDATA, 0);
      check("rst_disp_data", DISP_DATA, 0);
      check("rst_disp_valid", DISP_VALID, 0);
      check("rst_underrun", DISP_UNDERRUN, 0);
      check("rst_wa_ready", WA_READY, 0);
      check("rst_wb_ready", WB_READY, 0);
      do_preload = 1'b1;
      repeat (2) @(posedge CLK_PX);
      @(negedge CLK_PX);
      do_preload = 1'b0;
      RST_n = 1'b1;

      disp_read("disp640", 0, 640, 0);

      // Writer A, 20 beats in blanking.
      run(20, 100, 0, 0, 1'b0, 26);
      check("wa20_count", log_addr.size(), 20);
      bad = 0;
      for (int k = 0; k < log_addr.size(); k++)
         if ((log_addr[k] != 100 + k) || (log_data[k] != ((8'hA0 + k) & 255))) bad++;
      check("wa20_order_bad", bad, 0);
      if (log_cyc.size() == 20) check("wa20_consecutive", log_cyc[19] - log_cyc[0], 19);
      disp_read("wa20_readback", 100, 20, 8'hA0);

      // Out-of-range address passes through untouched.
      run(1, 307200, 0, 0, 1'b0, 6);
      check("oob_count", log_addr.size(), 1);
      if (log_addr.size() == 1) check("oob_addr", log_addr[0], 307200);

      // Writer A against a 1-on/1-off display.
      run(16, 300, 0, 0, 1'b1, 45);
      check("tog_ready_on_disp", rdy_bad, 0);
      check("tog_count", log_addr.size(), 16);
      bad = 0;
      for (int k = 0; k < log_addr.size(); k++)
         if ((log_addr[k] != 300 + k) || (log_data[k] != ((8'hA0 + k) & 255))) bad++;
      check("tog_order_bad", bad, 0);
      check("tog_underrun", DISP_UNDERRUN, 0);

      // Reset pulse after beat 3 of writer A.
      ia = 0; fa = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK_PX);
         if (fa) ia++;
         if (ia == 3) break;
         WA_VALID = 1'b1;
         WA_ADDR  = AW'(400 + ia);
         WA_DATA  = DW'(8'hA0 + ia);
         #1 fa = WA_VALID && WA_READY;
      end
      check("mid_beat3_addr", MEM_ADDR, 402);
      WA_ADDR = AW'(403);
      WA_DATA = 8'hA3;
      #5 RST_n = 1'b0;
      #1;
      check("mid_rst_mem_we", MEM_WE, 0);
      check("mid_rst_mem_addr", MEM_ADDR, 0);
      check("mid_rst_mem_wdata", MEM_WDATA, 0);
      check("mid_rst_wa_ready", WA_READY, 0);
      check("mid_rst_disp_valid", DISP_VALID, 0);
      check("mid_rst_disp_data", DISP_DATA, 0);
      @(negedge CLK_PX);
      RST_n = 1'b1;
      seen = 0; got_addr = 0; got_data = 0; fa = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK_PX);
         if (MEM_WE) begin
            seen = 1; got_addr = int'(MEM_ADDR); got_data = int'(MEM_WDATA);
            break;
         end
         if (fa) WA_VALID = 1'b0;
         #1 fa = WA_VALID && WA_READY;
      end
      WA_VALID = 1'b0;
      check("post_rst_write_seen", seen, 1);
      check("post_rst_addr", got_addr, 403);
      check("post_rst_data", got_data, 8'hA3);

      do_reset();
`ifdef FRAME_ARB_WB_EN
      run(40, 500, 40, 700, 1'b0, 30);
      check("rr_enough", log_addr.size() >= 24, 1);
      bad = 0;
      for (int k = 0; k < 24 && k < log_addr.size(); k++) begin
         int ea;
         if (k < 8)       ea = 500 + k;
         else if (k < 16) ea = 700 + k - 8;
         else             ea = 500 + k - 8;
         if (log_addr[k] != ea) bad++;
      end
      check("rr_sequence_bad", bad, 0);
      if (log_cyc.size() >= 24) check("rr_no_gaps", log_cyc[23] - log_cyc[0], 23);
`else
      run(32, 500, 1000, 700, 1'b0, 38);
      check("nowb_wb_ready", wb_rdy_cnt, 0);
      check("nowb_count", log_addr.size(), 32);
      bad = 0;
      for (int k = 0; k < log_addr.size(); k++) if (log_addr[k] != 500 + k) bad++;
      check("nowb_order_bad", bad, 0);
      if (log_cyc.size() == 32) check("nowb_unbroken", log_cyc[31] - log_cyc[0], 31);
`endif
      check("final_underrun", DISP_UNDERRUN, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Shares one single-port synchronous frame RAM between three users. The HDMI display fetch reads one pixel per active clock and has absolute priority. Two writers, an image loader (A) and an overlay/draw engine (B), share the remaining cycles through round-robin with bounded bursts. The block sits between the HDMI timing/pixel controller and the frame RAM, all in the CLK_PX domain.

## Interface
- ADDR_W, 19, frame RAM address width (640×480 = 307200 words)
- DATA_W, 8, pixel word width (greyscale)
- BURST_MAX, 8, maximum consecutive write beats granted to one writer while the other is requesting (≥1)
- CLK_PX  in  1  pixel clock (25 MHz)
- RST_n  in  1  asynchronous, active-low reset
- DISP_REQ  in  1  display read request, high during active video
- DISP_ADDR  in  ADDR_W  display read address
- DISP_DATA  out  DATA_W  read pixel
- DISP_VALID  out  1  DISP_DATA valid strobe
- WA_VALID / WA_READY  in / out  1  writer A handshake
- WA_ADDR, WA_DATA  in  ADDR_W, DATA_W  writer A write beat
- WB_VALID / WB_READY  in / out  1  writer B handshake
- WB_ADDR, WB_DATA  in  ADDR_W, DATA_W  writer B write beat
- MEM_ADDR  out  ADDR_W  registered RAM address
- MEM_WE  out  1  registered RAM write enable
- MEM_WDATA  out  DATA_W  registered RAM write data
- MEM_RDATA  in  DATA_W  RAM read data, one cycle after MEM_ADDR
- DISP_UNDERRUN  out  1  sticky flag: DISP_REQ seen while a write was committed in the same memory slot (must never set)

## Operation
- Slot priority in each cycle: display read first, then the current writer grant. Display reads are never stalled.
- Writer FSM states:
  - IDLE: no grant.
  - GNT_A: grant to writer A.
  - GNT_B: grant to writer B.
- Write transfers:
  - WA_READY = (state==GNT_A) & !DISP_REQ. WB_READY works the same way for GNT_B.
  - A beat transfers when VALID & READY.
- FSM transitions:
  - IDLE → GNT_A or GNT_B on any VALID. If both are valid, the one not served last wins. After reset, A wins.
  - GNT_x → other: when x drops VALID, or when x has transferred BURST_MAX beats and the other VALID is high.
  - GNT_x → IDLE: when x drops VALID and the other is not valid.
  - The burst counter resets on every grant change.
  - Cycles stalled by DISP_REQ do not count toward the burst. The grant holds through display activity.
- A writer must hold ADDR/DATA/VALID stable until it sees READY. The arbiter never drops an accepted beat.
- Address width is not checked. Addresses ≥ 307200 are passed through unchanged.
- DISP_UNDERRUN is a design assertion. It sets if MEM_WE and a display read are ever issued in the same registered slot, and clears only on reset.

## Timing
- Cycle N: DISP_REQ sampled. N+1: MEM_ADDR=DISP_ADDR, MEM_WE=0. N+2: MEM_RDATA returned. N+3: DISP_DATA registered and DISP_VALID=1.
- Fixed display latency is 3 cycles, with no bubbles across back-to-back requests.
- Write beat accepted at cycle N: MEM_ADDR, MEM_WDATA and MEM_WE=1 appear at N+1, for exactly one cycle per beat.
- Idle memory slot: MEM_WE=0 and MEM_ADDR holds its previous value.
- Grant change is visible on READY the cycle after the terminating condition. There is no dead cycle: GNT_A→GNT_B can accept B on the next cycle.
- Reset values: state=IDLE, all READY=0, MEM_ADDR=0, MEM_WE=0, MEM_WDATA=0, DISP_DATA=0, DISP_VALID=0, DISP_UNDERRUN=0, burst counter=0, last-served=B.
- Reset mid-burst:
  - An accepted beat not yet on the MEM port is discarded.
  - The read pipeline is flushed and DISP_VALID=0 on the next edge.
- Simultaneous DISP_REQ and VALID: the writer waits. The read issues.

## Configuration
- FRAME_ARB_WB_EN defined: writer B is arbitrated as above.
- Undefined:
  - WB_READY is tied 0 and the GNT_B state is removed.
  - Writer A keeps the grant for as long as it has data, and BURST_MAX is ignored.
  - Display behaviour is unchanged.

## Test plan
- Reset, then DISP_REQ high for 640 cycles with DISP_ADDR 0..639 and RAM preloaded with data=addr[7:0]:
  - DISP_VALID rises 3 cycles after the first request and stays high for 640 cycles.
  - DISP_DATA sequence is 0..255 repeating.
  - No MEM_WE.
- WA_VALID held high for 20 beats (addr 100..119, data 0xA0+i) during blanking: 20 single MEM_WE pulses on consecutive cycles, then reading back 100..119 returns identical data.
- WA and WB both continuously valid, BURST_MAX=8 (FRAME_ARB_WB_EN defined): grant sequence is A×8, B×8, A×8, with no idle cycles between switches.
- Writer A streaming while DISP_REQ toggles 1 cycle on / 1 off:
  - WA_READY is only ever high on DISP_REQ=0 cycles.
  - Every beat is written exactly once.
  - DISP_UNDERRUN remains 0.
- RST_n pulsed low mid-burst after beat 3 of writer A: all outputs return to reset values asynchronously, and after release A is regranted and the next MEM write uses the WA_ADDR presented at that point.
- FRAME_ARB_WB_EN undefined: WB_VALID=1 forever gives WB_READY=0 forever, and writer A streams 32 beats unbroken.
